spi_rx_sync: RTL and testbench

//   Parametrised SPI slave receiver running on the system clock. Oversamples
//   the async SPI pins, supports all four CPOL/CPHA modes, MSB/LSB-first order
//   and back-to-back words in one chip-select frame, and delivers each word

---
 rtl/spi_rx_sync.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_spi_rx_sync.sv | 574 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_sync.sv
// ---------------------------------------------------------------------------
// spi_rx_sync
//
// SPI slave receiver that runs entirely on the system clock. The SPI pins are
// treated as asynchronous inputs and oversampled through a synchroniser chain.
// The block then finds the sample edge of SCLK, shifts serial data into a
// word, and hands each completed word to the consumer through a valid/ready
// holding register.
//
// It supports all four CPOL/CPHA modes, MSB- or LSB-first bit order, and
// back-to-back words inside one chip-select frame.
//
// Parameters
//   WIDTH        bits per word (2..32)
//   CPOL         SCLK idle level
//   CPHA         0: sample on leading edge, 1: sample on trailing edge
//   LSB_FIRST    0: MSB first, 1: LSB first
//   SYNC_STAGES  synchroniser depth on sclk/cs/mosi (>= 2)
//
// Ports
//   clk        in   system clock; SCLK must be <= clk/4 (clk/8 with filter)
//   rst        in   asynchronous active-high reset
//   sclk       in   SPI clock (asynchronous)
//   cs         in   chip select, active low (asynchronous)
//   mosi       in   serial data in (asynchronous)
//   rx_data    out  received word, stable while rx_valid is high
//   rx_valid   out  a word is waiting in the holding register
//   rx_ready   in   consumer takes the word when rx_valid && rx_ready
//   overrun    out  one-cycle pulse: a completed word was dropped
//   frame_err  out  one-cycle pulse: cs rose with a partial word
//
// Build option
//   SPI_RX_DEGLITCH_EN  when defined, adds a 3-sample majority filter on the
//                       synchronised sclk and cs. This rejects single-clock
//                       glitches and adds 2 clocks of latency. mosi is delayed
//                       by the same amount so that it stays aligned with sclk.
//                       With the filter, SCLK must be <= clk/8.
// ---------------------------------------------------------------------------
module spi_rx_sync #(
   parameter int WIDTH       = 8,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int LSB_FIRST   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             cs,
   input  logic             mosi,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             overrun,
   output logic             frame_err
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   localparam logic SCLK_IDLE = (CPOL != 0);

   // Sampling happens on the rising edge when CPOL and CPHA agree,
   // and on the falling edge otherwise.
   localparam logic SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   // ------------------------------------------------------------------
   // Input synchronisers
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

   logic sclk_meta;
   logic cs_meta;
   logic mosi_meta;

   // Signals seen by the receiver after optional filtering.
   logic sclk_s;
   logic cs_s;
   logic mosi_s;

   // Each chain shifts toward its MSB, and the MSB is the synchronised value.
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   cs};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
   end

   // Reset presets the chains to the idle bus state: sclk at its idle level
   // and cs deasserted. This means that leaving reset never looks like an
   // edge or the start of a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
         cs_sync_q   <= {SYNC_STAGES{1'b1}};
         mosi_sync_q <= '0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
      end
   end

   assign sclk_meta = sclk_sync_q[SYNC_STAGES-1];
   assign cs_meta   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_meta = mosi_sync_q[SYNC_STAGES-1];

`ifdef SPI_RX_DEGLITCH_EN
   // ------------------------------------------------------------------
   // Majority deglitch filter
   // ------------------------------------------------------------------
   logic [1:0] sclk_hist_q, sclk_hist_d;
   logic [1:0] cs_hist_q,   cs_hist_d;
   logic       sclk_filt_q, sclk_filt_d;
   logic       cs_filt_q,   cs_filt_d;
   logic [1:0] mosi_dly_q,  mosi_dly_d;

   // The vote uses the current sample plus the two before it. Its result is
   // registered, so a clean step reaches the output 2 clocks later, while a
   // pulse that lasts one clock never wins the vote.
   always_comb begin
      sclk_hist_d = {sclk_hist_q[0], sclk_meta};
      cs_hist_d   = {cs_hist_q[0],   cs_meta};
      sclk_filt_d = (sclk_meta & sclk_hist_q[0]) | (sclk_meta & sclk_hist_q[1]) |
                    (sclk_hist_q[0] & sclk_hist_q[1]);
      cs_filt_d   = (cs_meta & cs_hist_q[0]) | (cs_meta & cs_hist_q[1]) |
                    (cs_hist_q[0] & cs_hist_q[1]);
      mosi_dly_d  = {mosi_dly_q[0], mosi_meta};
   end

   // mosi is not filtered. It only needs the same 2-clock delay so that
   // the bit sampled on an sclk edge is the bit that belongs to that edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_hist_q <= {2{SCLK_IDLE}};
         cs_hist_q   <= 2'b11;
         sclk_filt_q <= SCLK_IDLE;
         cs_filt_q   <= 1'b1;
         mosi_dly_q  <= 2'b00;
      end else begin
         sclk_hist_q <= sclk_hist_d;
         cs_hist_q   <= cs_hist_d;
         sclk_filt_q <= sclk_filt_d;
         cs_filt_q   <= cs_filt_d;
         mosi_dly_q  <= mosi_dly_d;
      end
   end

   assign sclk_s = sclk_filt_q;
   assign cs_s   = cs_filt_q;
   assign mosi_s = mosi_dly_q[1];
`else
   assign sclk_s = sclk_meta;
   assign cs_s   = cs_meta;
   assign mosi_s = mosi_meta;
`endif

   // ------------------------------------------------------------------
   // Receiver state
   // ------------------------------------------------------------------
   logic             sclk_prev_q, sclk_prev_d;
   logic [0:0]       state_q,     state_d;
   logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
   logic [WIDTH-1:0] shift_q,     shift_d;
   logic [WIDTH-1:0] rx_data_q,   rx_data_d;
   logic             rx_valid_q,  rx_valid_d;
   logic             overrun_q,   overrun_d;
   logic             frame_err_q, frame_err_d;

   logic             sample_edge;
   logic             cs_rise;
   logic             word_done;
   logic             load_word;
   logic [WIDTH-1:0] shift_next;

   // Edge detection and chip-select tracking.
   //
   // state_q holds the previous cs_s level. A cs rise is therefore
   // "ACTIVE last cycle, cs_s high now".
   //
   // Shifting requires cs_s low in the current cycle. Because of that, a
   // sample edge that arrives together with a cs rise is ignored
   // automatically.
   always_comb begin
      sclk_prev_d = sclk_s;
      state_d     = cs_s ? ST_IDLE : ST_ACTIVE;
      sample_edge = SAMPLE_RISE ? (sclk_s & ~sclk_prev_q) : (~sclk_s & sclk_prev_q);
      cs_rise     = (state_q == ST_ACTIVE) && cs_s;
   end

   // Shift path and bit counter.
   //
   // The completed word is taken from shift_next, which is the register
   // after this edge's bit has been added. This lets the holding register
   // load in the same cycle that the last bit arrives.
   always_comb begin
      if (LSB_FIRST != 0) begin
         shift_next = {mosi_s, shift_q[WIDTH-1:1]};
      end else begin
         shift_next = {shift_q[WIDTH-2:0], mosi_s};
      end

      word_done = !cs_s && sample_edge && (bit_cnt_q == LAST_CNT);
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;

      if (cs_s) begin
         bit_cnt_d = '0;
         shift_d   = '0;
      end else if (sample_edge) begin
         if (bit_cnt_q == LAST_CNT) begin
            bit_cnt_d = '0;
            shift_d   = '0;
         end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shift_d   = shift_next;
         end
      end
   end

   // Holding register and status pulses.
   //
   // A new word may load when the register is empty, or when the consumer
   // is taking the current word in the same cycle. In that case rx_valid
   // stays high and only rx_data changes.
   //
   // If the register is full and not being drained, the new word is
   // dropped and overrun is flagged. cs activity has no effect here, so a
   // pending word survives the end of its frame.
   always_comb begin
      load_word   = word_done && (!rx_valid_q || rx_ready);
      overrun_d   = word_done && rx_valid_q && !rx_ready;
      frame_err_d = cs_rise && (bit_cnt_q != '0);
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;

      if (load_word) begin
         rx_data_d  = shift_next;
         rx_valid_d = 1'b1;
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   // Registers for the receiver.
   //
   // Reset clears any partial word and any held word. It never produces a
   // status pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_prev_q <= SCLK_IDLE;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sclk_prev_q <= sclk_prev_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_rx_sync.sv
// ---------------------------------------------------------------------------
// tb_spi_rx_sync
//
// Drives two receivers, each from its own SPI master model:
//   dut_a : mode 0 (CPOL=0, CPHA=0), MSB first, 2 synchroniser stages
//   dut_b : mode 3 (CPOL=1, CPHA=1), LSB first, 3 synchroniser stages
//
// Every half SCLK period lasts 4 system clocks, so SCLK runs at clk/8.
//
// A monitor records every handshake transfer and counts the status pulses.
// Each scenario task compares those records against the words it sent, as
// reshaped by the protocol rules: duplicated bits for glitches, and drops
// for overruns.
// ---------------------------------------------------------------------------
module tb_spi_rx_sync;

   localparam int H = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   logic       sclk_a, cs_a, mosi_a, rx_ready_a;
   logic [7:0] rx_data_a;
   logic       rx_valid_a, overrun_a, frame_err_a;

   logic       sclk_b, cs_b, mosi_b, rx_ready_b;
   logic [7:0] rx_data_b;
   logic       rx_valid_b, overrun_b, frame_err_b;

   int checks   = 0;
   int failures = 0;

   logic rand_ready = 1'b0;
   int   low_run_a  = 0;
   int   low_run_b  = 0;

   logic [7:0] got_a[$];
   logic [7:0] got_b[$];
   int   ovr_a  = 0, ferr_a = 0, rise_a = 0;
   int   ovr_b  = 0, ferr_b = 0, rise_b = 0;
   logic prev_valid_a = 1'b0, prev_valid_b = 1'b0;

   spi_rx_sync #(.WIDTH(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .rst(rst), .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a),
      .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
      .overrun(overrun_a), .frame_err(frame_err_a)
   );

   spi_rx_sync #(.WIDTH(8), .CPOL(1), .CPHA(1), .LSB_FIRST(1), .SYNC_STAGES(3)) dut_b (
      .clk(clk), .rst(rst), .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b),
      .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
      .overrun(overrun_b), .frame_err(frame_err_b)
   );

   // Monitor.
   //
   // Outputs are sampled on the falling edge. At that point they hold the
   // values the receiver will see at the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid_a = 1'b0;
         prev_valid_b = 1'b0;
      end else begin
         if (rx_valid_a && rx_ready_a) got_a.push_back(rx_data_a);
         if (overrun_a) ovr_a++;
         if (frame_err_a) ferr_a++;
         if (rx_valid_a && !prev_valid_a) rise_a++;
         prev_valid_a = rx_valid_a;

         if (rx_valid_b && rx_ready_b) got_b.push_back(rx_data_b);
         if (overrun_b) ovr_b++;
         if (frame_err_b) ferr_b++;
         if (rx_valid_b && !prev_valid_b) rise_b++;
         prev_valid_b = rx_valid_b;
      end
   end

   // Watchdog: stops the run if it ever stops making progress.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advances by n clocks and leaves the bench 2ns after a rising edge.
   // While rand_ready is set, rx_ready is randomised. It is never held low
   // for more than 8 clocks in a row, which is much shorter than the time
   // it takes to receive one word.
   task automatic wait_clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
         if (rand_ready) begin
            if (low_run_a >= 8 || $urandom_range(0, 3) != 0) begin
               rx_ready_a = 1'b1;
               low_run_a  = 0;
            end else begin
               rx_ready_a = 1'b0;
               low_run_a++;
            end

            if (low_run_b >= 8 || $urandom_range(0, 3) != 0) begin
               rx_ready_b = 1'b1;
               low_run_b  = 0;
            end else begin
               rx_ready_b = 1'b0;
               low_run_b++;
            end
         end
      end
   endtask

   task automatic pin_sclk(input int inst, input logic v);
      if (inst == 0) sclk_a = v;
      else           sclk_b = v;
   endtask

   task automatic pin_cs(input int inst, input logic v);
      if (inst == 0) cs_a = v;
      else           cs_b = v;
   endtask

   task automatic pin_mosi(input int inst, input logic v);
      if (inst == 0) mosi_a = v;
      else           mosi_b = v;
   endtask

   task automatic cs_low(input int inst);
      pin_cs(inst, 1'b0);
      wait_clks(H);
   endtask

   task automatic cs_high(input int inst);
      wait_clks(H);
      pin_cs(inst, 1'b1);
      wait_clks(2 * H);
   endtask

   // SPI master model. It sends the first nbits of data in the bit order
   // used by the target receiver.
   //
   // glitch_at >= 0 adds a one-clock SCLK pulse during the idle half of
   // that bit. This is supported only for the mode-0 receiver.
   task automatic send_bits(input int inst, input logic [7:0] data,
                            input int nbits, input int glitch_at);
      logic pol;
      logic b;
      pol = (inst != 0);

      for (int i = 0; i < nbits; i++) begin
         b = (inst == 0) ? data[7 - i] : data[i];

         if (inst == 0) begin
            pin_mosi(inst, b);
            if (i == glitch_at) begin
               wait_clks(1);
               pin_sclk(inst, ~pol);
               wait_clks(1);
               pin_sclk(inst, pol);
               wait_clks(2);
            end else begin
               wait_clks(H);
            end
            pin_sclk(inst, ~pol);
            wait_clks(H);
            pin_sclk(inst, pol);
         end else begin
            pin_sclk(inst, ~pol);
            pin_mosi(inst, b);
            wait_clks(H);
            pin_sclk(inst, pol);
            wait_clks(H);
         end
      end
   endtask

   // Reference for a glitch in a mode-0 MSB-first frame. The extra sample
   // edge reads the bit at position pos a second time. The first 8 bits of
   // that stream form the word that is received.
   function automatic logic [7:0] dup_bit_word(input logic [7:0] w, input int pos);
      logic       bits[$];
      logic [7:0] r;

      for (int i = 0; i < 8; i++) bits.push_back(w[7 - i]);
      bits.insert(pos, w[7 - pos]);

      r = '0;
      for (int i = 0; i < 8; i++) r[7 - i] = bits[i];
      return r;
   endfunction

   task automatic test_reset();
      rst        = 1'b1;
      sclk_a     = 1'b0; cs_a = 1'b1; mosi_a = 1'b0; rx_ready_a = 1'b1;
      sclk_b     = 1'b1; cs_b = 1'b1; mosi_b = 1'b0; rx_ready_b = 1'b1;
      wait_clks(3);

      checks++;
      if ({rx_valid_a, overrun_a, frame_err_a, rx_data_a} !== 11'h000) begin
         failures++;
         $display("[TB] FAIL reset_a: got %h expected 000",
                  {rx_valid_a, overrun_a, frame_err_a, rx_data_a});
      end

      checks++;
      if ({rx_valid_b, overrun_b, frame_err_b, rx_data_b} !== 11'h000) begin
         failures++;
         $display("[TB] FAIL reset_b: got %h expected 000",
                  {rx_valid_b, overrun_b, frame_err_b, rx_data_b});
      end

      rst = 1'b0;
      wait_clks(6);

      checks++;
      if ({rx_valid_a, overrun_a, frame_err_a, rx_data_a} !== 11'h000) begin
         failures++;
         $display("[TB] FAIL post_reset_a: got %h expected 000",
                  {rx_valid_a, overrun_a, frame_err_a, rx_data_a});
      end

      checks++;
      if ({rx_valid_b, overrun_b, frame_err_b, rx_data_b} !== 11'h000) begin
         failures++;
         $display("[TB] FAIL post_reset_b: got %h expected 000",
                  {rx_valid_b, overrun_b, frame_err_b, rx_data_b});
      end
   endtask

   task automatic test_mode0_back_to_back();
      int         base, ob, fb, rb;
      logic [7:0] w0, w1;

      base = got_a.size(); ob = ovr_a; fb = ferr_a; rb = rise_a;

      cs_low(0);
      send_bits(0, 8'hA5, 8, -1);
      send_bits(0, 8'hB3, 8, -1);
      cs_high(0);
      wait_clks(4);

      w0 = (got_a.size() > base)     ? got_a[base]     : 8'hxx;
      w1 = (got_a.size() > base + 1) ? got_a[base + 1] : 8'hxx;

      checks++;
      if (got_a.size() - base !== 2) begin
         failures++;
         $display("[TB] FAIL m0_count: got %0d expected 2", got_a.size() - base);
      end

      checks++;
      if (w0 !== 8'hA5) begin
         failures++;
         $display("[TB] FAIL m0_word0: got %h expected a5", w0);
      end

      checks++;
      if (w1 !== 8'hB3) begin
         failures++;
         $display("[TB] FAIL m0_word1: got %h expected b3", w1);
      end

      checks++;
      if (rise_a - rb !== 2) begin
         failures++;
         $display("[TB] FAIL m0_valid_rises: got %0d expected 2", rise_a - rb);
      end

      checks++;
      if ((ovr_a - ob) + (ferr_a - fb) !== 0) begin
         failures++;
         $display("[TB] FAIL m0_pulses: got %0d expected 0", (ovr_a - ob) + (ferr_a - fb));
      end
   endtask

   task automatic test_mode3_lsb();
      int         base, fb;
      logic [7:0] w0;

      base = got_b.size(); fb = ferr_b;

      cs_low(1);
      send_bits(1, 8'h3C, 8, -1);
      cs_high(1);
      wait_clks(4);

      w0 = (got_b.size() > base) ? got_b[base] : 8'hxx;

      checks++;
      if (got_b.size() - base !== 1) begin
         failures++;
         $display("[TB] FAIL m3_count: got %0d expected 1", got_b.size() - base);
      end

      checks++;
      if (w0 !== 8'h3C) begin
         failures++;
         $display("[TB] FAIL m3_word: got %h expected 3c", w0);
      end

      checks++;
      if (ferr_b - fb !== 0) begin
         failures++;
         $display("[TB] FAIL m3_frame_err: got %0d expected 0", ferr_b - fb);
      end
   endtask

   task automatic test_overrun();
      int         base, ob;
      logic [7:0] w0;

      base = got_a.size(); ob = ovr_a;

      rx_ready_a = 1'b0;
      cs_low(0);
      send_bits(0, 8'h11, 8, -1);
      send_bits(0, 8'h22, 8, -1);
      cs_high(0);

      checks++;
      if ({rx_valid_a, rx_data_a} !== 9'h111) begin
         failures++;
         $display("[TB] FAIL ovr_held: got %h expected 111", {rx_valid_a, rx_data_a});
      end

      checks++;
      if (ovr_a - ob !== 1) begin
         failures++;
         $display("[TB] FAIL ovr_pulses: got %0d expected 1", ovr_a - ob);
      end

      rx_ready_a = 1'b1;
      wait_clks(3);

      w0 = (got_a.size() > base) ? got_a[base] : 8'hxx;

      checks++;
      if (rx_valid_a !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ovr_valid_drop: got %b expected 0", rx_valid_a);
      end

      checks++;
      if (got_a.size() - base !== 1) begin
         failures++;
         $display("[TB] FAIL ovr_count: got %0d expected 1", got_a.size() - base);
      end

      checks++;
      if (w0 !== 8'h11) begin
         failures++;
         $display("[TB] FAIL ovr_word: got %h expected 11", w0);
      end
   endtask

   task automatic test_frame_err();
      int         base, fb, rb;
      logic [7:0] w0;

      base = got_a.size(); fb = ferr_a; rb = rise_a;

      cs_low(0);
      send_bits(0, 8'($urandom), 5, -1);
      cs_high(0);

      checks++;
      if (ferr_a - fb !== 1) begin
         failures++;
         $display("[TB] FAIL ferr_pulse: got %0d expected 1", ferr_a - fb);
      end

      checks++;
      if (rise_a - rb !== 0) begin
         failures++;
         $display("[TB] FAIL ferr_no_valid: got %0d expected 0", rise_a - rb);
      end

      cs_low(0);
      send_bits(0, 8'h5A, 8, -1);
      cs_high(0);
      wait_clks(4);

      w0 = (got_a.size() > base) ? got_a[base] : 8'hxx;

      checks++;
      if (w0 !== 8'h5A) begin
         failures++;
         $display("[TB] FAIL ferr_next_word: got %h expected 5a", w0);
      end

      checks++;
      if (ferr_a - fb !== 1) begin
         failures++;
         $display("[TB] FAIL ferr_next_clean: got %0d expected 1", ferr_a - fb);
      end
   endtask

   task automatic test_reset_mid_word();
      int         base, fb, rb;
      logic [7:0] w0;

      // Leave a word pending so the asynchronous clear is observable.
      rx_ready_a = 1'b0;
      cs_low(0);
      send_bits(0, 8'h96, 8, -1);
      cs_high(0);

      cs_low(0);
      send_bits(0, 8'hFF, 4, -1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;

      checks++;
      if ({rx_valid_a, overrun_a, frame_err_a, rx_data_a} !== 11'h000) begin
         failures++;
         $display("[TB] FAIL rst_mid_outputs: got %h expected 000",
                  {rx_valid_a, overrun_a, frame_err_a, rx_data_a});
      end

      pin_cs(0, 1'b1);
      pin_sclk(0, 1'b0);
      wait_clks(3);
      rst        = 1'b0;
      rx_ready_a = 1'b1;
      wait_clks(4);

      base = got_a.size(); fb = ferr_a; rb = rise_a;

      cs_low(0);
      send_bits(0, 8'h81, 8, -1);
      cs_high(0);
      wait_clks(4);

      w0 = (got_a.size() > base) ? got_a[base] : 8'hxx;

      checks++;
      if (w0 !== 8'h81) begin
         failures++;
         $display("[TB] FAIL rst_next_word: got %h expected 81", w0);
      end

      checks++;
      if (rise_a - rb !== 1) begin
         failures++;
         $display("[TB] FAIL rst_next_valid: got %0d expected 1", rise_a - rb);
      end

      checks++;
      if (ferr_a - fb !== 0) begin
         failures++;
         $display("[TB] FAIL rst_no_frame_err: got %0d expected 0", ferr_a - fb);
      end
   endtask

   task automatic test_deglitch();
      int         base, fb, exp_ferr;
      logic [7:0] w0, exp_word;

`ifdef SPI_RX_DEGLITCH_EN
      exp_word = 8'hC3;
      exp_ferr = 0;
`else
      exp_word = dup_bit_word(8'hC3, 2);
      exp_ferr = 1;
`endif

      base = got_a.size(); fb = ferr_a;

      cs_low(0);
      send_bits(0, 8'hC3, 8, 2);
      cs_high(0);
      wait_clks(4);

      w0 = (got_a.size() > base) ? got_a[base] : 8'hxx;

      checks++;
      if (w0 !== exp_word) begin
         failures++;
         $display("[TB] FAIL glitch_word: got %h expected %h", w0, exp_word);
      end

      checks++;
      if (ferr_a - fb !== exp_ferr) begin
         failures++;
         $display("[TB] FAIL glitch_frame_err: got %0d expected %0d", ferr_a - fb, exp_ferr);
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_a[$];
      logic [7:0] exp_b[$];
      int         base_a, base_b, oa, ob, fa, fbb;
      int         inst, nw;
      logic [7:0] w, g;

      base_a = got_a.size(); base_b = got_b.size();
      oa = ovr_a; ob = ovr_b; fa = ferr_a; fbb = ferr_b;

      rand_ready = 1'b1;
      for (int rep = 0; rep < 8; rep++) begin
         inst = rep % 2;
         nw   = $urandom_range(1, 3);
         cs_low(inst);
         for (int k = 0; k < nw; k++) begin
            w = 8'($urandom);
            if (inst == 0) exp_a.push_back(w);
            else           exp_b.push_back(w);
            send_bits(inst, w, 8, -1);
         end
         cs_high(inst);
      end
      rand_ready = 1'b0;
      rx_ready_a = 1'b1;
      rx_ready_b = 1'b1;
      wait_clks(4);

      checks++;
      if (got_a.size() - base_a !== exp_a.size()) begin
         failures++;
         $display("[TB] FAIL rand_count_a: got %0d expected %0d",
                  got_a.size() - base_a, exp_a.size());
      end

      checks++;
      if (got_b.size() - base_b !== exp_b.size()) begin
         failures++;
         $display("[TB] FAIL rand_count_b: got %0d expected %0d",
                  got_b.size() - base_b, exp_b.size());
      end

      foreach (exp_a[i]) begin
         g = (got_a.size() > base_a + i) ? got_a[base_a + i] : 8'hxx;
         checks++;
         if (g !== exp_a[i]) begin
            failures++;
            $display("[TB] FAIL rand_word_a[%0d]: got %h expected %h", i, g, exp_a[i]);
         end
      end

      foreach (exp_b[i]) begin
         g = (got_b.size() > base_b + i) ? got_b[base_b + i] : 8'hxx;
         checks++;
         if (g !== exp_b[i]) begin
            failures++;
            $display("[TB] FAIL rand_word_b[%0d]: got %h expected %h", i, g, exp_b[i]);
         end
      end

      checks++;
      if ((ovr_a - oa) + (ovr_b - ob) + (ferr_a - fa) + (ferr_b - fbb) !== 0) begin
         failures++;
         $display("[TB] FAIL rand_pulses: got %0d expected 0",
                  (ovr_a - oa) + (ovr_b - ob) + (ferr_a - fa) + (ferr_b - fbb));
      end
   endtask

   initial begin
      test_reset();
      test_mode0_back_to_back();
      test_mode3_lsb();
      test_overrun();
      test_frame_err();
      test_reset_mid_word();
      test_deglitch();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
